reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Arithmetic and branch reservation station; sits directly downstream of the reorder buffer.
- Accepts non-load/store instructions dispatched by the ROB and holds them until both operands are available.
- Operands become available by capturing commit broadcasts (tag = producer PC).
- Issues one ready instruction per cycle to the ALU. Load/store instructions are routed to the SLB and ignored here.

Parameters:
- ENTRIES, 8, number of station slots (power of two, 2..16)
- IDX_W, 3, log2(ENTRIES)
- DATA_W, 32, operand/immediate/PC width
- OP_W, 6, opcode width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- is_empty_from_rob  in  1  1 = no dispatch this cycle
- is_sl_from_rob  in  1  1 = dispatched op is load/store (not for this block)
- is_exception_from_rob  in  1  flush request
- pc_from_rob  in  DATA_W  PC of dispatched op (its own tag)
- op_from_rob  in  OP_W  opcode
- v1_from_rob, v2_from_rob  in  DATA_W  operand values
- q1_from_rob, q2_from_rob  in  DATA_W  operand tags; 0 = value already valid
- imm_from_rob  in  DATA_W  immediate
- is_commit_from_rob  in  1  commit broadcast valid
- commit_pc_from_rob  in  DATA_W  committed producer tag
- commit_data_from_rob  in  DATA_W  committed result
- is_full_to_rob  out  1  all slots busy (combinational from registered state)
- is_valid_to_alu  out  1  issue valid (registered)
- op_to_alu  out  OP_W, registered
- v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu  out  DATA_W, registered

Behaviour:
- Reset (async, rst=1): all busy bits 0, all ages 0. is_valid_to_alu=0; op/v/imm/pc outputs 0; is_full_to_rob=0.
- Accept: dispatch is accepted when is_empty_from_rob=0, is_sl_from_rob=0, is_exception_from_rob=0 and is_full_to_rob=0.
  - Writes the lowest-index free slot with busy=1, age=0.
  - Full is judged on pre-edge state; a slot freed by an issue in the same cycle is not reusable until the next cycle.
  - A dispatch offered while full is dropped. The ROB must hold it; is_full_to_rob signals this.
- Wake-up: when is_commit_from_rob=1, every busy slot with q1==commit_pc (q1!=0) gets v1 <= commit_data and q1 <= 0. Same for q2/v2.
- Dispatch bypass: if the accepted dispatch has q1 or q2 equal to the same-cycle commit_pc, it is stored with that operand resolved (q=0, v=commit_data). This bypass is mandatory.
- Ready: a slot is ready when busy=1, q1=0 and q2=0, using registered state only. A slot woken in cycle N is issuable in cycle N+1 at the earliest.
- Issue: at most one per cycle. The selected ready slot is copied into the output registers, is_valid_to_alu=1 for exactly one cycle, and the slot's busy bit is cleared. With no ready slot, is_valid_to_alu=0 and the data outputs hold their previous values.
- Latency: dispatch in cycle N with ready operands means issue is visible after edge N+1 (is_valid_to_alu high during cycle N+2). Minimum 1 cycle residency.
- Age: on each accepted dispatch, the age of every other busy slot increments, saturating at 2^IDX_W+... (max representable 4 bits, 15).
- Flush (is_exception_from_rob=1 at a clock edge): all busy bits clear, is_valid_to_alu <= 0, no accept, no issue, no wake-up that cycle. The flush takes priority over every other event.
- Reset mid-operation: state is lost immediately, with no wait for the clock.
- Tag 0 is reserved as "ready"; the ROB never uses 0 as a producer tag.

Optional Feature:
- Macro RS_OLDEST_FIRST_EN.
- Defined: issue selects the ready slot with the largest age; ties go to the lower index.
- Undefined: issue selects the lowest-index ready slot. Age registers are not synthesized.

Test Plan:
- Reset, then dispatch ADD pc=0x100, v1=3, v2=4, q1=q2=0 → is_valid_to_alu=1 two cycles later with pc_to_alu=0x100, v1_to_alu=3, v2_to_alu=4. No further valid follows.
- Dispatch pc=0x104 with q1=0x100. Broadcast commit pc=0x100 data=0x55 three cycles later → issue on the cycle after the wake-up with v1_to_alu=0x55.
- Dispatch with q2=0x200 in the same cycle as commit pc=0x200 data=7 (bypass) → issues as if ready with v2_to_alu=7. No hang.
- Dispatch 8 ops with unresolved tags → is_full_to_rob=1. A 9th dispatch is not stored. Resolving one tag → exactly that op issues and full drops the next cycle.
- Two ready ops: slot 3 dispatched first, slot 1 dispatched later → with RS_OLDEST_FIRST_EN slot 3 issues first; without it slot 1 issues first.
- Fill 4 slots, pulse is_exception_from_rob → no is_valid_to_alu afterwards, is_full_to_rob=0. A new dispatch is accepted into slot 0.

Source files
------------

// File: rtl/reservation_station.sv
// Arithmetic/branch reservation station: holds dispatched ops until both operands
// are resolved by commit broadcasts, then issues one ready op per cycle to the ALU.
// Optional RS_OLDEST_FIRST_EN: issue picks the oldest ready slot instead of the lowest index.
module reservation_station #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_empty_from_rob,
  input  logic              is_sl_from_rob,
  input  logic              is_exception_from_rob,
  input  logic [DATA_W-1:0] pc_from_rob,
  input  logic [OP_W-1:0]   op_from_rob,
  input  logic [DATA_W-1:0] v1_from_rob,
  input  logic [DATA_W-1:0] v2_from_rob,
  input  logic [DATA_W-1:0] q1_from_rob,
  input  logic [DATA_W-1:0] q2_from_rob,
  input  logic [DATA_W-1:0] imm_from_rob,
  input  logic              is_commit_from_rob,
  input  logic [DATA_W-1:0] commit_pc_from_rob,
  input  logic [DATA_W-1:0] commit_data_from_rob,
  output logic              is_full_to_rob,
  output logic              is_valid_to_alu,
  output logic [OP_W-1:0]   op_to_alu,
  output logic [DATA_W-1:0] v1_to_alu,
  output logic [DATA_W-1:0] v2_to_alu,
  output logic [DATA_W-1:0] imm_to_alu,
  output logic [DATA_W-1:0] pc_to_alu
);

  logic [ENTRIES-1:0] r_busy;
  logic [DATA_W-1:0]  r_q1  [ENTRIES];
  logic [DATA_W-1:0]  r_q2  [ENTRIES];
  logic [DATA_W-1:0]  r_v1  [ENTRIES];
  logic [DATA_W-1:0]  r_v2  [ENTRIES];
  logic [DATA_W-1:0]  r_imm [ENTRIES];
  logic [DATA_W-1:0]  r_pc  [ENTRIES];
  logic [OP_W-1:0]    r_op  [ENTRIES];
`ifdef RS_OLDEST_FIRST_EN
  logic [3:0]         r_age [ENTRIES];
`endif

  logic [ENTRIES-1:0] w_ready;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_free_found;
  logic [IDX_W-1:0]   w_issue_idx;
  logic               w_issue_vld;
  logic               w_accept;
  logic               w_byp1;
  logic               w_byp2;

  assign is_full_to_rob = &r_busy;
  assign w_accept = !is_empty_from_rob && !is_sl_from_rob && !is_exception_from_rob &&
                    w_free_found;
  // Same-cycle commit resolves the incoming operand so it is never missed.
  assign w_byp1 = is_commit_from_rob && (q1_from_rob != '0) && (q1_from_rob == commit_pc_from_rob);
  assign w_byp2 = is_commit_from_rob && (q2_from_rob != '0) && (q2_from_rob == commit_pc_from_rob);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
    end
  end

  always_comb begin
    w_free_idx   = '0;
    w_free_found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!r_busy[i] && !w_free_found) begin
        w_free_idx   = IDX_W'(i);
        w_free_found = 1'b1;
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // Strict '>' keeps the lower index on equal ages.
  always_comb begin
    w_issue_idx = '0;
    w_issue_vld = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_ready[i] && (!w_issue_vld || (r_age[i] > r_age[w_issue_idx]))) begin
        w_issue_idx = IDX_W'(i);
        w_issue_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_issue_idx = '0;
    w_issue_vld = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_ready[i] && !w_issue_vld) begin
        w_issue_idx = IDX_W'(i);
        w_issue_vld = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy          <= '0;
      is_valid_to_alu <= 1'b0;
      op_to_alu       <= '0;
      v1_to_alu       <= '0;
      v2_to_alu       <= '0;
      imm_to_alu      <= '0;
      pc_to_alu       <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_q1[i]  <= '0;
        r_q2[i]  <= '0;
        r_v1[i]  <= '0;
        r_v2[i]  <= '0;
        r_imm[i] <= '0;
        r_pc[i]  <= '0;
        r_op[i]  <= '0;
`ifdef RS_OLDEST_FIRST_EN
        r_age[i] <= '0;
`endif
      end
    end else if (is_exception_from_rob) begin
      r_busy          <= '0;
      is_valid_to_alu <= 1'b0;
    end else begin
      is_valid_to_alu <= w_issue_vld;
      if (w_issue_vld) begin
        op_to_alu           <= r_op[w_issue_idx];
        v1_to_alu           <= r_v1[w_issue_idx];
        v2_to_alu           <= r_v2[w_issue_idx];
        imm_to_alu          <= r_imm[w_issue_idx];
        pc_to_alu           <= r_pc[w_issue_idx];
        r_busy[w_issue_idx] <= 1'b0;
      end
      if (is_commit_from_rob) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (r_busy[i] && (r_q1[i] != '0) && (r_q1[i] == commit_pc_from_rob)) begin
            r_v1[i] <= commit_data_from_rob;
            r_q1[i] <= '0;
          end
          if (r_busy[i] && (r_q2[i] != '0) && (r_q2[i] == commit_pc_from_rob)) begin
            r_v2[i] <= commit_data_from_rob;
            r_q2[i] <= '0;
          end
        end
      end
      // The free slot is never busy, so this write cannot collide with wake-up or issue.
      if (w_accept) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= op_from_rob;
        r_imm[w_free_idx]  <= imm_from_rob;
        r_pc[w_free_idx]   <= pc_from_rob;
        r_q1[w_free_idx]   <= w_byp1 ? '0 : q1_from_rob;
        r_v1[w_free_idx]   <= w_byp1 ? commit_data_from_rob : v1_from_rob;
        r_q2[w_free_idx]   <= w_byp2 ? '0 : q2_from_rob;
        r_v2[w_free_idx]   <= w_byp2 ? commit_data_from_rob : v2_from_rob;
`ifdef RS_OLDEST_FIRST_EN
        for (int i = 0; i < ENTRIES; i++) begin
          if (r_busy[i] && (r_age[i] != 4'hF)) begin
            r_age[i] <= r_age[i] + 4'd1;
          end
        end
        r_age[w_free_idx] <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed latency/wake-up/bypass/full/
// ordering/flush/reset checks plus a scoreboard comparing every issued op.
module tb_reservation_station;

  localparam int DW    = 32;
  localparam int OW    = 6;
  localparam int EXP_W = OW + 4 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          is_empty_from_rob, is_sl_from_rob, is_exception_from_rob;
  logic [DW-1:0] pc_from_rob, v1_from_rob, v2_from_rob, q1_from_rob, q2_from_rob, imm_from_rob;
  logic [OW-1:0] op_from_rob;
  logic          is_commit_from_rob;
  logic [DW-1:0] commit_pc_from_rob, commit_data_from_rob;
  logic          is_full_to_rob, is_valid_to_alu;
  logic [OW-1:0] op_to_alu;
  logic [DW-1:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;

  logic [EXP_W-1:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;

  reservation_station dut (
    .clk(clk), .rst(rst),
    .is_empty_from_rob(is_empty_from_rob), .is_sl_from_rob(is_sl_from_rob),
    .is_exception_from_rob(is_exception_from_rob),
    .pc_from_rob(pc_from_rob), .op_from_rob(op_from_rob),
    .v1_from_rob(v1_from_rob), .v2_from_rob(v2_from_rob),
    .q1_from_rob(q1_from_rob), .q2_from_rob(q2_from_rob), .imm_from_rob(imm_from_rob),
    .is_commit_from_rob(is_commit_from_rob), .commit_pc_from_rob(commit_pc_from_rob),
    .commit_data_from_rob(commit_data_from_rob),
    .is_full_to_rob(is_full_to_rob), .is_valid_to_alu(is_valid_to_alu),
    .op_to_alu(op_to_alu), .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
    .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack(input logic [OW-1:0] op, input logic [DW-1:0] v1,
                                            input logic [DW-1:0] v2, input logic [DW-1:0] imm,
                                            input logic [DW-1:0] pc);
    return {op, v1, v2, imm, pc};
  endfunction

  // driver tasks
  task automatic set_idle();
    is_empty_from_rob = 1'b1; is_sl_from_rob = 1'b0; is_exception_from_rob = 1'b0;
    is_commit_from_rob = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic drive_dispatch(input logic [DW-1:0] pc, input logic [OW-1:0] op,
                                input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                                input logic [DW-1:0] q1, input logic [DW-1:0] q2,
                                input logic [DW-1:0] imm);
    is_empty_from_rob = 1'b0;
    pc_from_rob = pc; op_from_rob = op; v1_from_rob = v1; v2_from_rob = v2;
    q1_from_rob = q1; q2_from_rob = q2; imm_from_rob = imm;
  endtask

  task automatic drive_commit(input logic [DW-1:0] pc, input logic [DW-1:0] data);
    is_commit_from_rob = 1'b1; commit_pc_from_rob = pc; commit_data_from_rob = data;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_empty", 160'(exp_q.size()), 160'd0);
    #1;
  endtask

  // scoreboard: every issue must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && is_valid_to_alu) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue_pc", 160'(pc_to_alu), 160'hDEAD_0000);
      end else begin
        chk("issue_data", 160'({op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu}),
            160'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [DW-1:0] rv1, rv2, rimm;
    logic [OW-1:0] rop;
    rst = 1'b1;
    pc_from_rob = '0; op_from_rob = '0; v1_from_rob = '0; v2_from_rob = '0;
    q1_from_rob = '0; q2_from_rob = '0; imm_from_rob = '0;
    commit_pc_from_rob = '0; commit_data_from_rob = '0;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 160'({is_valid_to_alu, is_full_to_rob, op_to_alu, v1_to_alu,
        v2_to_alu, imm_to_alu, pc_to_alu}), 160'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ready dispatch: 2-cycle latency, single valid pulse, outputs hold afterwards
    drive_dispatch(32'h100, 6'd1, 32'd3, 32'd4, 32'd0, 32'd0, 32'h11);
    exp_q.push_back(pack(6'd1, 32'd3, 32'd4, 32'h11, 32'h100));
    step();
    @(negedge clk);
    chk("lat_not_yet", 160'(is_valid_to_alu), 160'd0);
    step();
    @(negedge clk);
    chk("lat_valid", 160'(is_valid_to_alu), 160'd1);
    chk("lat_pc", 160'(pc_to_alu), 160'h100);
    step();
    @(negedge clk);
    chk("single_pulse", 160'(is_valid_to_alu), 160'd0);
    chk("hold_pc", 160'(pc_to_alu), 160'h100);

    // wake-up via commit three cycles after dispatch
    step();
    drive_dispatch(32'h104, 6'd2, 32'd0, 32'd9, 32'h100, 32'd0, 32'h10);
    step(); step(); step();
    drive_commit(32'h100, 32'h55);
    exp_q.push_back(pack(6'd2, 32'h55, 32'd9, 32'h10, 32'h104));
    step();
    @(negedge clk);
    chk("wake_not_same_cycle", 160'(is_valid_to_alu), 160'd0);
    step();
    @(negedge clk);
    chk("wake_issue", 160'(is_valid_to_alu), 160'd1);
    chk("wake_v1", 160'(v1_to_alu), 160'h55);

    // dispatch bypass from same-cycle commit
    step();
    drive_dispatch(32'h108, 6'd3, 32'd1, 32'd0, 32'd0, 32'h200, 32'h20);
    drive_commit(32'h200, 32'd7);
    exp_q.push_back(pack(6'd3, 32'd1, 32'd7, 32'h20, 32'h108));
    step(); step();
    @(negedge clk);
    chk("bypass_issue", 160'(is_valid_to_alu), 160'd1);
    chk("bypass_v2", 160'(v2_to_alu), 160'd7);
    wait_drain();

    // random ready ops with random gaps; order is preserved
    for (int k = 0; k < 8; k++) begin
      rv1 = $urandom; rv2 = $urandom; rimm = $urandom; rop = OW'($urandom_range(0, 63));
      drive_dispatch(32'h800 + 32'(k * 4), rop, rv1, rv2, 32'd0, 32'd0, rimm);
      exp_q.push_back(pack(rop, rv1, rv2, rimm, 32'h800 + 32'(k * 4)));
      step();
      repeat ($urandom_range(0, 2)) step();
    end
    wait_drain();

    // fill all slots, drop a dispatch while full, free one slot
    for (int k = 0; k < 8; k++) begin
      drive_dispatch(32'h300 + 32'(k * 4), 6'd4, 32'(k), 32'd0, 32'h1000 + 32'(k), 32'd0, 32'd0);
      step();
    end
    @(negedge clk);
    chk("full_set", 160'(is_full_to_rob), 160'd1);
    step();
    drive_dispatch(32'h999, 6'd5, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0);
    step();
    drive_commit(32'h1003, 32'hAB);
    exp_q.push_back(pack(6'd4, 32'hAB, 32'd0, 32'd0, 32'h30C));
    step();
    @(negedge clk);
    chk("full_still", 160'(is_full_to_rob), 160'd1);
    step();
    @(negedge clk);
    chk("full_dropped", 160'(is_full_to_rob), 160'd0);
    chk("full_issue", 160'(is_valid_to_alu), 160'd1);
    step();
    is_exception_from_rob = 1'b1;
    step();
    @(negedge clk);
    chk("flush_clears_full", 160'(is_full_to_rob), 160'd0);
    wait_drain();

    // issue order: slot 3 dispatched before slot 1, both become ready together
    drive_dispatch(32'h500, 6'd6, 32'd0, 32'd0, 32'h2000, 32'd0, 32'd0); step();
    drive_dispatch(32'h504, 6'd6, 32'd0, 32'd0, 32'h2001, 32'd0, 32'd0); step();
    drive_dispatch(32'h508, 6'd6, 32'd0, 32'd0, 32'h2002, 32'd0, 32'd0); step();
    drive_dispatch(32'h50C, 6'd7, 32'd0, 32'd0, 32'h2100, 32'd0, 32'd0); step();
    drive_commit(32'h2001, 32'd1);
    exp_q.push_back(pack(6'd6, 32'd1, 32'd0, 32'd0, 32'h504));
    step();
    wait_drain();
    drive_dispatch(32'h510, 6'd8, 32'd0, 32'd0, 32'h2100, 32'd0, 32'd0); step();
    drive_commit(32'h2100, 32'h77);
`ifdef RS_OLDEST_FIRST_EN
    exp_q.push_back(pack(6'd7, 32'h77, 32'd0, 32'd0, 32'h50C));
    exp_q.push_back(pack(6'd8, 32'h77, 32'd0, 32'd0, 32'h510));
`else
    exp_q.push_back(pack(6'd8, 32'h77, 32'd0, 32'd0, 32'h510));
    exp_q.push_back(pack(6'd7, 32'h77, 32'd0, 32'd0, 32'h50C));
`endif
    step();
    wait_drain();
    is_exception_from_rob = 1'b1;
    step();

    // flush with a ready slot pending plus a same-cycle dispatch and commit
    for (int k = 0; k < 4; k++) begin
      drive_dispatch(32'h400 + 32'(k * 4), 6'd9, 32'd0, 32'd0, 32'h3000 + 32'(k), 32'd0, 32'd0);
      step();
    end
    drive_dispatch(32'h600, 6'd10, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0);
    step();
    drive_dispatch(32'h604, 6'd10, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0);
    drive_commit(32'h3000, 32'd5);
    is_exception_from_rob = 1'b1;
    step();
    @(negedge clk);
    chk("flush_no_issue", 160'(is_valid_to_alu), 160'd0);
    chk("flush_not_full", 160'(is_full_to_rob), 160'd0);
    for (int k = 1; k < 4; k++) begin
      drive_commit(32'h3000 + 32'(k), 32'd5);
      step();
    end
    repeat (3) step();
    drive_dispatch(32'h700, 6'd11, 32'hA, 32'hB, 32'd0, 32'd0, 32'hC);
    exp_q.push_back(pack(6'd11, 32'hA, 32'hB, 32'hC, 32'h700));
    step();
    wait_drain();

    // asynchronous reset mid-cycle
    drive_dispatch(32'h900, 6'd12, 32'd0, 32'd0, 32'h4000, 32'd0, 32'd0);
    step();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 160'({is_valid_to_alu, is_full_to_rob, op_to_alu, v1_to_alu,
        v2_to_alu, imm_to_alu, pc_to_alu}), 160'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_commit(32'h4000, 32'd1);
    step();
    repeat (4) step();
    chk("final_queue", 160'(exp_q.size()), 160'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
